// File: rtl/branch_ctrl_if.sv
// Bus between branch_ctrl and the core: IF prediction lookup, EX branch
// presentation, comparator drive/result, and redirect/flush controls.
interface branch_ctrl_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [2:0]  cmp_op;
  logic        br_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal_br;

  // Redirect handshake: redirect_valid is a single-cycle pulse with no
  // back-pressure; fetch must take redirect_pc in the cycle it is high.
  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target,
           ex_pred_taken, ex_funct3, ex_rs1, ex_rs2, br_en,
    output pred_taken, cmp_a, cmp_b, cmp_op, redirect_valid, redirect_pc,
           flush, illegal_br
  );

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target,
           ex_pred_taken, ex_funct3, ex_rs1, ex_rs2, br_en,
    input  pred_taken, cmp_a, cmp_b, cmp_op, redirect_valid, redirect_pc,
           flush, illegal_br
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: 2-bit BHT prediction, EX resolution, redirect
// and multi-cycle flush. Optional counters enabled by BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  branch_ctrl_if.slave bus,
  output logic dbg_state
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               flush_q, flush_d;
  logic               illegal_q, illegal_d;
  logic [1:0]         bht_q [BHT_ENTRIES];
  logic [1:0]         bht_d [BHT_ENTRIES];

  logic [IDX_W-1:0]   idx_if, idx_ex;
  logic               reserved, resolve, actual, mispredict;
  logic [31:0]        target;
  logic               unused_pc_bits;

  assign bus.cmp_a  = bus.ex_rs1;
  assign bus.cmp_b  = bus.ex_rs2;
  assign bus.cmp_op = bus.ex_funct3;

  assign idx_if         = bus.if_pc[IDX_W+1:2];
  assign idx_ex         = bus.ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

  // Read sees the pre-update counter; no bypass from a same-cycle EX write.
  assign bus.pred_taken = bht_q[idx_if][1];

  assign reserved   = (bus.ex_funct3[2:1] == 2'b01);
  assign resolve    = bus.ex_valid & bus.ex_is_branch & ~bus.ex_stall & (state_q == IDLE);
  assign actual     = ~reserved & bus.br_en;
  assign mispredict = resolve & (actual != bus.ex_pred_taken);
  assign target     = actual ? bus.ex_target : bus.ex_pc + 32'd4;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    illegal_d        = resolve & reserved;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d          = FLUSH;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          flush_d          = 1'b1;
          cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bht_d = bht_q;
    if (resolve && !reserved) begin
      if (actual) begin
        if (bht_q[idx_ex] != 2'b11) bht_d[idx_ex] = bht_q[idx_ex] + 2'b01;
      end else begin
        if (bht_q[idx_ex] != 2'b00) bht_d[idx_ex] = bht_q[idx_ex] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      illegal_q        <= 1'b0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      illegal_q        <= illegal_d;
      bht_q            <= bht_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.illegal_br     = illegal_q;
  assign dbg_state          = state_q;

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (resolve && stat_branches_q != 32'hFFFF_FFFF)
      stat_branches_d = stat_branches_q + 32'd1;
    if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF)
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: redirect/illegal pulses go through an
// expected queue checked by a monitor; prediction and flush timing are checked inline.
module tb_branch_ctrl;
  logic clk;
  logic rst_n;
  logic dbg_state;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];

  branch_ctrl_if bif ();

  branch_ctrl #(.BHT_ENTRIES(64), .FLUSH_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif),
    .dbg_state (dbg_state)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference comparator; reserved ops return 1 so an RTL that used br_en would show it.
  always_comb begin
    case (bif.cmp_op)
      3'b000:  bif.br_en = (bif.cmp_a == bif.cmp_b);
      3'b001:  bif.br_en = (bif.cmp_a != bif.cmp_b);
      3'b100:  bif.br_en = ($signed(bif.cmp_a) <  $signed(bif.cmp_b));
      3'b101:  bif.br_en = ($signed(bif.cmp_a) >= $signed(bif.cmp_b));
      3'b110:  bif.br_en = (bif.cmp_a <  bif.cmp_b);
      3'b111:  bif.br_en = (bif.cmp_a >= bif.cmp_b);
      default: bif.br_en = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  task automatic pop_cmp(input string name, input logic [32:0] act);
    logic [32:0] exp;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: got unexpected 0x%0h expected nothing", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.redirect_valid) pop_cmp("redirect", {1'b0, bif.redirect_pc});
      if (bif.illegal_br)     pop_cmp("illegal_br", {1'b1, 32'h0});
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bif.ex_pc         = pc;
    bif.ex_target     = tgt;
    bif.ex_pred_taken = pred;
    bif.ex_funct3     = f3;
    bif.ex_rs1        = a;
    bif.ex_rs2        = b;
    bif.ex_valid      = 1'b1;
    bif.ex_is_branch  = 1'b1;
  endtask

  task automatic clr_br();
    bif.ex_valid     = 1'b0;
    bif.ex_is_branch = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    set_br(pc, tgt, pred, f3, a, b);
    tick();
    clr_br();
  endtask

  task automatic expect_redirect(input logic [31:0] pc);
    exp_q.push_back({1'b0, pc});
  endtask

  task automatic expect_illegal();
    exp_q.push_back({1'b1, 32'h0});
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    bif.if_pc = pc;
    #1;
    check(name, {32'h0, bif.pred_taken}, {32'h0, exp});
  endtask

  // Flush must read 1,1,0 on the three negedges after the mispredict edge.
  task automatic flush_window(input string name);
    @(negedge clk);
    check({name, "_flush1"}, {32'h0, bif.flush}, 33'h1);
    check({name, "_state1"}, {32'h0, dbg_state}, 33'h1);
    @(negedge clk);
    check({name, "_flush2"}, {32'h0, bif.flush}, 33'h1);
    @(negedge clk);
    check({name, "_flush3"}, {32'h0, bif.flush}, 33'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.if_pc = 32'h0;
    bif.ex_stall = 1'b0;
    bif.ex_pc = 32'h0;
    bif.ex_target = 32'h0;
    bif.ex_pred_taken = 1'b0;
    bif.ex_funct3 = 3'b000;
    bif.ex_rs1 = 32'h0;
    bif.ex_rs2 = 32'h0;
    clr_br();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flush", {32'h0, bif.flush}, 33'h0);
    check("rst_redirect_valid", {32'h0, bif.redirect_valid}, 33'h0);
    check("rst_redirect_pc", {1'b0, bif.redirect_pc}, 33'h0);
    check("rst_illegal", {32'h0, bif.illegal_br}, 33'h0);
    check("rst_state", {32'h0, dbg_state}, 33'h0);
    rst_n = 1'b1;
    tick();

    // Taken beq predicted not-taken: 01 -> 10, redirect to target
    check_pred("pred_0x100_rst", 32'h100, 1'b0);
    expect_redirect(32'h200);
    issue(32'h100, 32'h200, 1'b0, 3'b000, 32'd5, 32'd5);
    check_pred("pred_0x100_after", 32'h100, 1'b1);
    flush_window("beq");

    // Correct blt (signed -1 < 1): 10 -> 11 -> 11
    issue(32'h100, 32'h180, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1);
    check_pred("blt_inc", 32'h100, 1'b1);
    @(negedge clk);
    check("blt_noflush", {32'h0, bif.flush}, 33'h0);
    issue(32'h100, 32'h180, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1);
    check_pred("blt_sat", 32'h100, 1'b1);
    expect_redirect(32'h104);
    issue(32'h100, 32'h180, 1'b1, 3'b001, 32'd7, 32'd7);
    check_pred("bne_dec1", 32'h100, 1'b1);
    flush_window("bne1");
    expect_redirect(32'h104);
    issue(32'h100, 32'h180, 1'b1, 3'b001, 32'd7, 32'd7);
    check_pred("bne_dec2", 32'h100, 1'b0);
    flush_window("bne2");

    // bgeu not taken at top of address space wraps to 0; EX branch during flush ignored
    expect_redirect(32'h0);
    issue(32'hFFFF_FFFC, 32'h40, 1'b1, 3'b111, 32'd1, 32'hFFFF_FFFF);
    set_br(32'h300, 32'h380, 1'b0, 3'b000, 32'd3, 32'd3);
    flush_window("bgeu");
    clr_br();
    check_pred("flush_ignore_bht", 32'h300, 1'b0);
    check_pred("bgeu_dec", 32'hFFFF_FFFC, 1'b0);

    // Reserved funct3
    expect_illegal();
    issue(32'h400, 32'h480, 1'b0, 3'b010, 32'd9, 32'd9);
    check_pred("illegal_bht", 32'h400, 1'b0);
    @(negedge clk);
    check("illegal_noflush", {32'h0, bif.flush}, 33'h0);
    expect_redirect(32'h504);
    expect_illegal();
    issue(32'h500, 32'h580, 1'b1, 3'b011, 32'd9, 32'd9);
    check_pred("illegal_pred1_bht", 32'h500, 1'b0);
    flush_window("illegal_pred1");

    // Stalled mispredicting bne, then reset mid-flush
    set_br(32'h600, 32'h700, 1'b0, 3'b001, 32'd1, 32'd2);
    bif.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_redirect", {32'h0, bif.redirect_valid}, 33'h0);
      check("stall_no_flush", {32'h0, bif.flush}, 33'h0);
    end
    expect_redirect(32'h700);
    bif.ex_stall = 1'b0;
    tick();
    clr_br();
    @(negedge clk);
    check("stall_flush", {32'h0, bif.flush}, 33'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midflush_rst_flush", {32'h0, bif.flush}, 33'h0);
    check("midflush_rst_state", {32'h0, dbg_state}, 33'h0);
    check("midflush_rst_rpc", {1'b0, bif.redirect_pc}, 33'h0);
    for (int i = 0; i < 64; i++) check_pred("rst_bht_entry", 32'(i) << 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset counter is 01: one taken flips prediction. Then 10 resolves, 3 mispredicts.
    issue(32'hFFFF_FFFC, 32'h0, 1'b1, 3'b000, 32'd4, 32'd4);
    check_pred("rst_ctr_01", 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 6; i++) issue(32'h900 + 32'(i * 4), 32'h990, 1'b1, 3'b000, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      expect_redirect(32'hA04 + 32'(i * 4));
      issue(32'hA00 + 32'(i * 4), 32'hB00, 1'b1, 3'b000, 32'd0, 32'd1);
      flush_window("stats_mp");
    end
`ifdef BRANCH_CTRL_STATS_EN
    check("stat_branches", {1'b0, stat_branches}, 33'd10);
    check("stat_mispredicts", {1'b0, stat_mispredicts}, 33'd3);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", 33'(exp_q.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
